// File: rtl/excp_commit_ctrl_pkg.sv
// Shared CSR definitions for the exception commit path: Ecode constants,
// commit-controller state encoding and the 82-bit csr_bus record layout.
package excp_commit_ctrl_pkg;

  localparam int CSR_BUS_WD = 82;

  // csr_bus bit offsets, MSB first
  localparam int BUS_IS_ETRN     = 81;
  localparam int BUS_IN_EXCP     = 80;
  localparam int BUS_ECODE_LSB   = 74;
  localparam int BUS_SUBCODE_LSB = 65;
  localparam int BUS_ERA_LSB     = 33;
  localparam int BUS_USE_BADV    = 32;
  localparam int BUS_BADV_LSB    = 0;

  localparam logic [5:0] ECODE_INT = 6'h00;
  localparam logic [5:0] ECODE_ADE = 6'h08;
  localparam logic [5:0] ECODE_ALE = 6'h09;
  localparam logic [5:0] ECODE_SYS = 6'h0B;
  localparam logic [5:0] ECODE_BRK = 6'h0C;
  localparam logic [5:0] ECODE_INE = 6'h0D;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_COMMIT = 2'd2,
    ST_FLUSH  = 2'd3
  } excp_state_e;

  typedef struct packed {
    logic        is_etrn;
    logic        in_excp;
    logic [5:0]  ecode;
    logic [8:0]  subcode;
    logic [31:0] era;
    logic        use_badv;
    logic [31:0] badv;
  } csr_rec_t;

  // Even parity over a record, for consumers that protect the bus
  function automatic logic rec_parity(input csr_rec_t rec);
    return ^rec;
  endfunction

endpackage

// File: rtl/excp_commit_ctrl.sv
// Exception / interrupt / ERTN commit controller: latches the winning request,
// waits out in-flight CSR writes, presents the record for one cycle, then flushes.
module excp_commit_ctrl
  import excp_commit_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [5:0]  ECODE_INT    = 6'h00
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cm_valid,
  input  logic [31:0]           cm_pc,
  input  logic                  ex_valid,
  input  logic [5:0]            ex_ecode,
  input  logic [8:0]            ex_subcode,
  input  logic                  ex_use_badv,
  input  logic [31:0]           ex_badv,
  input  logic                  ertn_valid,
  input  logic                  have_intrpt,
  input  logic                  csr_wr_busy,
  output logic                  ex_ack,
  output logic [CSR_BUS_WD-1:0] csr_bus,
  output logic                  flush,
  output logic                  commit_stall
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  excp_state_e           state_r, state_nxt_s;
  logic [3:0]            cnt_r, cnt_nxt_s;
  csr_rec_t              rec_r, rec_nxt_s, fresh_rec_s;
  logic                  ack_src_r, ack_src_nxt_s, fresh_ack_s;
  logic                  event_s;
  logic [CSR_BUS_WD-1:0] csr_bus_r;
  logic                  ex_ack_r, flush_r, commit_stall_r;

  assign event_s = cm_valid & (have_intrpt | ex_valid | ertn_valid);

  // Build the candidate record by priority: interrupt > exception > ERTN
  always_comb begin
    fresh_rec_s = '0;
    fresh_ack_s = 1'b0;
    if (have_intrpt) begin
      fresh_rec_s.in_excp = 1'b1;
      fresh_rec_s.ecode   = ECODE_INT;
      fresh_rec_s.era     = cm_pc;
    end else if (ex_valid) begin
      fresh_rec_s.in_excp  = 1'b1;
      fresh_rec_s.ecode    = ex_ecode;
      fresh_rec_s.subcode  = ex_subcode;
      fresh_rec_s.era      = cm_pc;
      fresh_rec_s.use_badv = ex_use_badv;
      fresh_rec_s.badv     = ex_badv;
      fresh_ack_s          = 1'b1;
    end else if (ertn_valid) begin
      fresh_rec_s.is_etrn = 1'b1;
      fresh_ack_s         = 1'b1;
    end else begin
      fresh_rec_s = '0;
    end
  end

  // Next-state, flush counter and request latch
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    rec_nxt_s     = rec_r;
    ack_src_nxt_s = ack_src_r;
    case (state_r)
      ST_IDLE: begin
        if (event_s) begin
          rec_nxt_s     = fresh_rec_s;
          ack_src_nxt_s = fresh_ack_s;
          state_nxt_s   = csr_wr_busy ? ST_DRAIN : ST_COMMIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (csr_wr_busy) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        state_nxt_s = ST_FLUSH;
        cnt_nxt_s   = FLUSH_LOAD;
      end
      ST_FLUSH: begin
        if (cnt_r <= 4'd1) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = 4'd0;
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // State and output registers; outputs are pre-decoded from the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      cnt_r          <= 4'd0;
      rec_r          <= '0;
      ack_src_r      <= 1'b0;
      csr_bus_r      <= '0;
      ex_ack_r       <= 1'b0;
      flush_r        <= 1'b0;
      commit_stall_r <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      cnt_r          <= cnt_nxt_s;
      rec_r          <= rec_nxt_s;
      ack_src_r      <= ack_src_nxt_s;
      csr_bus_r      <= (state_nxt_s == ST_COMMIT) ? CSR_BUS_WD'(rec_nxt_s) : '0;
      ex_ack_r       <= (state_nxt_s == ST_COMMIT) & ack_src_nxt_s;
      flush_r        <= (state_nxt_s == ST_FLUSH);
      commit_stall_r <= (state_nxt_s != ST_IDLE);
    end
  end

  assign csr_bus      = csr_bus_r;
  assign ex_ack       = ex_ack_r;
  assign flush        = flush_r;
  assign commit_stall = commit_stall_r;

endmodule

// File: doc/excp_commit_ctrl.md
EXCP_COMMIT_CTRL -- requirements
Module: excp_commit_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, number of cycles flush stays asserted after a commit (range 1..15).
REQ-002 SHALL have parameter ECODE_INT, default 6'h00, Ecode used for interrupts.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 cm_valid  input  1  commit stage holds a valid instruction.
REQ-006 cm_pc  input  32  PC of the commit-stage instruction.
REQ-007 ex_valid  input  1  commit instruction raised an exception; held until ex_ack.
REQ-008 ex_ecode / ex_subcode  input  6 / 9  exception Ecode / EsubCode.
REQ-009 ex_use_badv / ex_badv  input  1 / 32  bad-address valid flag / value.
REQ-010 ertn_valid  input  1  commit instruction is ERTN; held until ex_ack.
REQ-011 have_intrpt  input  1  level from the CSR file: enabled interrupt pending.
REQ-012 csr_wr_busy  input  1  a CSR write is presented to the CSR file this cycle.
REQ-013 ex_ack  output  1  one-cycle pulse: request consumed; source drops it next cycle.
REQ-014 csr_bus  output  82  {is_etrn, in_excp, ecode[5:0], subcode[8:0], era[31:0], use_badv, badv[31:0]}, MSB first.
REQ-015 flush  output  1  kill all younger pipeline contents.
REQ-016 commit_stall  output  1  block commit-stage retirement.

Function
REQ-017 States: IDLE, DRAIN, COMMIT, FLUSH; 2-bit encoding.
REQ-018 IDLE: event = cm_valid & (have_intrpt | ex_valid | ertn_valid); event with csr_wr_busy=1 -> DRAIN; without -> COMMIT.
REQ-019 Priority, latched on leaving IDLE: interrupt > exception > ERTN; latched request held in registers, not re-sampled.
REQ-020 Interrupt: ecode=ECODE_INT, subcode=0, era=cm_pc, use_badv=0; if ex_valid/ertn_valid also high they are NOT acked (instruction re-executes after handler).
REQ-021 Exception: ecode/subcode/use_badv/badv from ex_*, era=cm_pc. ERTN: is_etrn=1, in_excp=0, other fields zero.
REQ-022 DRAIN: commit_stall=1; stays while csr_wr_busy=1; -> COMMIT first cycle csr_wr_busy=0. csr_bus all-zero in DRAIN (no exception coincides with a CSR write).
REQ-023 COMMIT lasts exactly one cycle: csr_bus carries latched record with in_excp or is_etrn=1; ex_ack=1 iff latched source is exception or ERTN; -> FLUSH.
REQ-024 FLUSH: flush=1 and commit_stall=1 for FLUSH_CYCLES cycles via down-counter, then IDLE; csr_bus zero.
REQ-025 commit_stall=1 also in COMMIT; commit_stall=0 and flush=0 in IDLE.
REQ-026 No new event accepted outside IDLE; have_intrpt changes in DRAIN/COMMIT/FLUSH ignored.
REQ-027 Event-to-commit latency: 1 cycle (IDLE->COMMIT) when csr_wr_busy=0; 1+N when busy for N cycles.
REQ-028 Back-to-back: event present on return to IDLE accepted that same cycle.
REQ-029 csr_bus and ex_ack driven from registers/state only; no combinational path from inputs to outputs.

Reset
REQ-030 rst_n=0 at a clock edge: state=IDLE, counter=0, latched record=0; all outputs 0 next cycle, including mid-DRAIN/FLUSH.
REQ-031 No ex_ack or csr_bus pulse issued in the cycle reset releases.

Structure
REQ-032 State encoding, csr_bus field widths/offsets and CSR_BUS_WD=82 SHALL live in the shared CSR define header alongside Ecode constants.
REQ-033 Single module; no sub-module; counter width 4 bits.

Verification
REQ-034 Exception ecode 6'h0B at cm_pc 32'h1C00_0100, busy=0 -> COMMIT next cycle: in_excp=1, era=1C00_0100, ex_ack pulse; flush high 2 cycles.
REQ-035 have_intrpt and ex_valid together -> ecode=0, use_badv=0, no ex_ack; exception re-accepted after FLUSH if still held.
REQ-036 Exception with csr_wr_busy high 3 cycles -> 3 DRAIN cycles, csr_bus zero, then COMMIT; latency 4.
REQ-037 ertn_valid alone -> is_etrn=1, in_excp=0, ex_ack pulse, flush 2 cycles.
REQ-038 Exception ecode 6'h08, badv 32'hDEAD_BEEF, use_badv=1 -> csr_bus badv field DEAD_BEEF, use_badv=1.
REQ-039 rst_n low during 2nd FLUSH cycle -> next cycle IDLE, flush=0, commit_stall=0, csr_bus=0.
